// File: rtl/rs_alu_pkg.sv
// Shared definitions for the ALU reservation station: default sizing and opcode encodings.
package rs_alu_pkg;

   localparam int DEF_RS_SIZE = 16;
   localparam int DEF_ROB_W   = 4;
   localparam int XLEN        = 32;

   typedef enum logic [5:0] {
      OP_NOP  = 6'd0,
      OP_LUI  = 6'd1,
      OP_AUIPC = 6'd2,
      OP_JAL  = 6'd3,
      OP_JALR = 6'd4,
      OP_BEQ  = 6'd5,
      OP_BNE  = 6'd6,
      OP_ADD  = 6'd20,
      OP_SUB  = 6'd21,
      OP_ADDI = 6'd30,
      OP_XORI = 6'd31
   } opcode_e;

endpackage

// File: rtl/rs_alu_picker.sv
// Lowest-index priority encoder: reports whether any request bit is set and which one wins.
module rs_picker #(
   parameter int N     = 16,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   // Scan from the top so the lowest set bit is the last one to overwrite idx.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/rs_alu.sv
// Reservation station for the integer/branch ALU: captures dispatched instructions, snoops both
// result buses for pending operands and issues one ready instruction per cycle via output registers.
module rs_alu
   import rs_alu_pkg::*;
#(
   parameter int RS_SIZE = DEF_RS_SIZE,
   parameter int ROB_W   = DEF_ROB_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             rollback,
   input  logic             iss_flag,
   input  logic [5:0]       iss_inst_code,
   input  logic             iss_Q1_busy,
   input  logic             iss_Q2_busy,
   input  logic [ROB_W-1:0] iss_Q1,
   input  logic [ROB_W-1:0] iss_Q2,
   input  logic [31:0]      iss_V1,
   input  logic [31:0]      iss_V2,
   input  logic [31:0]      iss_A,
   input  logic [31:0]      iss_pc,
   input  logic [ROB_W-1:0] iss_rob_id,
   input  logic             ex_cdb_flag,
   input  logic [31:0]      ex_cdb_rob_id,
   input  logic [31:0]      ex_cdb_val,
   input  logic             ld_cdb_flag,
   input  logic [ROB_W-1:0] ld_cdb_rob_id,
   input  logic [31:0]      ld_cdb_val,
   output logic             rs_full,
   output logic             RS_flag,
   output logic [31:0]      RS_V1,
   output logic [31:0]      RS_V2,
   output logic [31:0]      RS_A,
   output logic [31:0]      RS_inst_pc,
   output logic [5:0]       RS_inst_code,
   output logic [31:0]      RS_inst_rob_id
);

   localparam int IDX_W = $clog2(RS_SIZE);

   logic [RS_SIZE-1:0] valid_q, valid_d;
   logic [RS_SIZE-1:0] q1_busy_q, q1_busy_d;
   logic [RS_SIZE-1:0] q2_busy_q, q2_busy_d;
   logic [5:0]         code_q [RS_SIZE];
   logic [5:0]         code_d [RS_SIZE];
   logic [ROB_W-1:0]   q1_q   [RS_SIZE];
   logic [ROB_W-1:0]   q1_d   [RS_SIZE];
   logic [ROB_W-1:0]   q2_q   [RS_SIZE];
   logic [ROB_W-1:0]   q2_d   [RS_SIZE];
   logic [ROB_W-1:0]   rob_q  [RS_SIZE];
   logic [ROB_W-1:0]   rob_d  [RS_SIZE];
   logic [31:0]        v1_q   [RS_SIZE];
   logic [31:0]        v1_d   [RS_SIZE];
   logic [31:0]        v2_q   [RS_SIZE];
   logic [31:0]        v2_d   [RS_SIZE];
   logic [31:0]        a_q    [RS_SIZE];
   logic [31:0]        a_d    [RS_SIZE];
   logic [31:0]        pc_q   [RS_SIZE];
   logic [31:0]        pc_d   [RS_SIZE];

   logic               out_flag_q, out_flag_d;
   logic [31:0]        out_v1_q, out_v1_d;
   logic [31:0]        out_v2_q, out_v2_d;
   logic [31:0]        out_a_q, out_a_d;
   logic [31:0]        out_pc_q, out_pc_d;
   logic [5:0]         out_code_q, out_code_d;
   logic [ROB_W-1:0]   out_rob_q, out_rob_d;

   logic [RS_SIZE-1:0] free_vec, ready_vec;
   logic               free_found, ready_found;
   logic [IDX_W-1:0]   free_idx, sel_idx;
   logic [ROB_W-1:0]   ex_tag;
   logic               unused_ex_tag_hi;

   // Only the low ROB_W bits of the ALU bus tag identify a ROB entry.
   assign ex_tag           = ex_cdb_rob_id[ROB_W-1:0];
   assign unused_ex_tag_hi = ^ex_cdb_rob_id[31:ROB_W];

   assign free_vec  = ~valid_q;
   assign ready_vec = valid_q & ~q1_busy_q & ~q2_busy_q;
   assign rs_full   = &valid_q;

   rs_picker #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_pick (
      .req   (free_vec),
      .found (free_found),
      .idx   (free_idx)
   );

   rs_picker #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_pick (
      .req   (ready_vec),
      .found (ready_found),
      .idx   (sel_idx)
   );

   // The free slot is always invalid and the selected slot always valid, so write and free never collide.
   always_comb begin
      valid_d    = valid_q;
      q1_busy_d  = q1_busy_q;
      q2_busy_d  = q2_busy_q;
      code_d     = code_q;
      q1_d       = q1_q;
      q2_d       = q2_q;
      rob_d      = rob_q;
      v1_d       = v1_q;
      v2_d       = v2_q;
      a_d        = a_q;
      pc_d       = pc_q;
      out_flag_d = out_flag_q;
      out_v1_d   = out_v1_q;
      out_v2_d   = out_v2_q;
      out_a_d    = out_a_q;
      out_pc_d   = out_pc_q;
      out_code_d = out_code_q;
      out_rob_d  = out_rob_q;

      if (rollback) begin
         valid_d    = '0;
         out_flag_d = 1'b0;
      end else if (!rdy) begin
         out_flag_d = 1'b0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (valid_q[i] && q1_busy_q[i]) begin
               if (ex_cdb_flag && q1_q[i] == ex_tag) begin
                  q1_busy_d[i] = 1'b0;
                  v1_d[i]      = ex_cdb_val;
               end else if (ld_cdb_flag && q1_q[i] == ld_cdb_rob_id) begin
                  q1_busy_d[i] = 1'b0;
                  v1_d[i]      = ld_cdb_val;
               end
            end
            if (valid_q[i] && q2_busy_q[i]) begin
               if (ex_cdb_flag && q2_q[i] == ex_tag) begin
                  q2_busy_d[i] = 1'b0;
                  v2_d[i]      = ex_cdb_val;
               end else if (ld_cdb_flag && q2_q[i] == ld_cdb_rob_id) begin
                  q2_busy_d[i] = 1'b0;
                  v2_d[i]      = ld_cdb_val;
               end
            end
         end

         out_flag_d = ready_found;
         if (ready_found) begin
            out_v1_d         = v1_q[sel_idx];
            out_v2_d         = v2_q[sel_idx];
            out_a_d          = a_q[sel_idx];
            out_pc_d         = pc_q[sel_idx];
            out_code_d       = code_q[sel_idx];
            out_rob_d        = rob_q[sel_idx];
            valid_d[sel_idx] = 1'b0;
         end

         if (iss_flag && !rs_full && free_found) begin
            valid_d[free_idx]   = 1'b1;
            code_d[free_idx]    = iss_inst_code;
            q1_d[free_idx]      = iss_Q1;
            q2_d[free_idx]      = iss_Q2;
            rob_d[free_idx]     = iss_rob_id;
            a_d[free_idx]       = iss_A;
            pc_d[free_idx]      = iss_pc;
            q1_busy_d[free_idx] = iss_Q1_busy;
            v1_d[free_idx]      = iss_V1;
            q2_busy_d[free_idx] = iss_Q2_busy;
            v2_d[free_idx]      = iss_V2;
            // A producer broadcasting in the dispatch cycle would otherwise be missed forever.
            if (iss_Q1_busy && ex_cdb_flag && iss_Q1 == ex_tag) begin
               q1_busy_d[free_idx] = 1'b0;
               v1_d[free_idx]      = ex_cdb_val;
            end else if (iss_Q1_busy && ld_cdb_flag && iss_Q1 == ld_cdb_rob_id) begin
               q1_busy_d[free_idx] = 1'b0;
               v1_d[free_idx]      = ld_cdb_val;
            end
            if (iss_Q2_busy && ex_cdb_flag && iss_Q2 == ex_tag) begin
               q2_busy_d[free_idx] = 1'b0;
               v2_d[free_idx]      = ex_cdb_val;
            end else if (iss_Q2_busy && ld_cdb_flag && iss_Q2 == ld_cdb_rob_id) begin
               q2_busy_d[free_idx] = 1'b0;
               v2_d[free_idx]      = ld_cdb_val;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '0;
         q1_busy_q  <= '0;
         q2_busy_q  <= '0;
         out_flag_q <= 1'b0;
         out_v1_q   <= '0;
         out_v2_q   <= '0;
         out_a_q    <= '0;
         out_pc_q   <= '0;
         out_code_q <= '0;
         out_rob_q  <= '0;
      end else begin
         valid_q    <= valid_d;
         q1_busy_q  <= q1_busy_d;
         q2_busy_q  <= q2_busy_d;
         code_q     <= code_d;
         q1_q       <= q1_d;
         q2_q       <= q2_d;
         rob_q      <= rob_d;
         v1_q       <= v1_d;
         v2_q       <= v2_d;
         a_q        <= a_d;
         pc_q       <= pc_d;
         out_flag_q <= out_flag_d;
         out_v1_q   <= out_v1_d;
         out_v2_q   <= out_v2_d;
         out_a_q    <= out_a_d;
         out_pc_q   <= out_pc_d;
         out_code_q <= out_code_d;
         out_rob_q  <= out_rob_d;
      end
   end

   assign RS_flag        = out_flag_q;
   assign RS_V1          = out_v1_q;
   assign RS_V2          = out_v2_q;
   assign RS_A           = out_a_q;
   assign RS_inst_pc     = out_pc_q;
   assign RS_inst_code   = out_code_q;
   assign RS_inst_rob_id = {{(32 - ROB_W){1'b0}}, out_rob_q};

endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: directed scenarios followed by random traffic, all compared
// every cycle against a behavioural model of the reservation station.
module tb_rs_alu;
   import rs_alu_pkg::*;

   localparam int N  = 16;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst, rdy, rollback, iss_flag;
   logic [5:0]    iss_inst_code;
   logic          iss_Q1_busy, iss_Q2_busy;
   logic [RW-1:0] iss_Q1, iss_Q2, iss_rob_id;
   logic [31:0]   iss_V1, iss_V2, iss_A, iss_pc;
   logic          ex_cdb_flag, ld_cdb_flag;
   logic [31:0]   ex_cdb_rob_id, ex_cdb_val, ld_cdb_val;
   logic [RW-1:0] ld_cdb_rob_id;
   logic          rs_full, RS_flag;
   logic [31:0]   RS_V1, RS_V2, RS_A, RS_inst_pc, RS_inst_rob_id;
   logic [5:0]    RS_inst_code;

   int nVec = 0;
   int nMis = 0;

   // One model entry: what the station must remember about a waiting instruction.
   typedef struct {
      logic          v;
      logic [5:0]    code;
      logic          b1, b2;
      logic [RW-1:0] t1, t2, rob;
      logic [31:0]   v1, v2, a, pc;
   } ent_t;

   ent_t        mdl [N];
   logic        eFlag;
   logic [31:0] eV1, eV2, eA, ePc, eRob;
   logic [5:0]  eCode;

   rs_alu dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .rollback       (rollback),
      .iss_flag       (iss_flag),
      .iss_inst_code  (iss_inst_code),
      .iss_Q1_busy    (iss_Q1_busy),
      .iss_Q2_busy    (iss_Q2_busy),
      .iss_Q1         (iss_Q1),
      .iss_Q2         (iss_Q2),
      .iss_V1         (iss_V1),
      .iss_V2         (iss_V2),
      .iss_A          (iss_A),
      .iss_pc         (iss_pc),
      .iss_rob_id     (iss_rob_id),
      .ex_cdb_flag    (ex_cdb_flag),
      .ex_cdb_rob_id  (ex_cdb_rob_id),
      .ex_cdb_val     (ex_cdb_val),
      .ld_cdb_flag    (ld_cdb_flag),
      .ld_cdb_rob_id  (ld_cdb_rob_id),
      .ld_cdb_val     (ld_cdb_val),
      .rs_full        (rs_full),
      .RS_flag        (RS_flag),
      .RS_V1          (RS_V1),
      .RS_V2          (RS_V2),
      .RS_A           (RS_A),
      .RS_inst_pc     (RS_inst_pc),
      .RS_inst_code   (RS_inst_code),
      .RS_inst_rob_id (RS_inst_rob_id)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nMis++;
         $error("[TB] FAIL %s: observed %08h expected %08h", name, obs, exp);
      end
   endtask

   function automatic int modelCount();
      int c = 0;
      for (int i = 0; i < N; i++) if (mdl[i].v) c++;
      return c;
   endfunction

   // Operand resolution against the buses as currently driven; ALU bus wins on a shared tag.
   task automatic resolve(input logic busy, input logic [RW-1:0] tag, input logic [31:0] val,
                          output logic ob, output logic [31:0] ov);
      if (!busy) begin
         ob = 1'b0; ov = val;
      end else if (ex_cdb_flag && ex_cdb_rob_id[RW-1:0] == tag) begin
         ob = 1'b0; ov = ex_cdb_val;
      end else if (ld_cdb_flag && ld_cdb_rob_id == tag) begin
         ob = 1'b0; ov = ld_cdb_val;
      end else begin
         ob = 1'b1; ov = val;
      end
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic modelStep();
      int fr = -1;
      int sel = -1;
      logic nb;
      logic [31:0] nv;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            mdl[i].v = 1'b0; mdl[i].b1 = 1'b0; mdl[i].b2 = 1'b0;
         end
         eFlag = 1'b0; eV1 = '0; eV2 = '0; eA = '0; ePc = '0; eCode = '0; eRob = '0;
      end else if (rollback) begin
         for (int i = 0; i < N; i++) mdl[i].v = 1'b0;
         eFlag = 1'b0;
      end else if (!rdy) begin
         eFlag = 1'b0;
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (!mdl[i].v) fr = i;
            if (mdl[i].v && !mdl[i].b1 && !mdl[i].b2) sel = i;
         end
         eFlag = (sel >= 0);
         if (sel >= 0) begin
            eV1 = mdl[sel].v1; eV2 = mdl[sel].v2; eA = mdl[sel].a; ePc = mdl[sel].pc;
            eCode = mdl[sel].code; eRob = 32'(mdl[sel].rob);
            mdl[sel].v = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (mdl[i].v) begin
               resolve(mdl[i].b1, mdl[i].t1, mdl[i].v1, nb, nv); mdl[i].b1 = nb; mdl[i].v1 = nv;
               resolve(mdl[i].b2, mdl[i].t2, mdl[i].v2, nb, nv); mdl[i].b2 = nb; mdl[i].v2 = nv;
            end
         end
         if (iss_flag && fr >= 0) begin
            mdl[fr].v = 1'b1; mdl[fr].code = iss_inst_code; mdl[fr].rob = iss_rob_id;
            mdl[fr].t1 = iss_Q1; mdl[fr].t2 = iss_Q2; mdl[fr].a = iss_A; mdl[fr].pc = iss_pc;
            resolve(iss_Q1_busy, iss_Q1, iss_V1, nb, nv); mdl[fr].b1 = nb; mdl[fr].v1 = nv;
            resolve(iss_Q2_busy, iss_Q2, iss_V2, nb, nv); mdl[fr].b2 = nb; mdl[fr].v2 = nv;
         end
      end
   endtask

   task automatic checkModel();
      checkOutput("RS_flag", 32'(RS_flag), 32'(eFlag));
      checkOutput("rs_full", 32'(rs_full), 32'(modelCount() == N));
      checkOutput("RS_V1", RS_V1, eV1);
      checkOutput("RS_V2", RS_V2, eV2);
      checkOutput("RS_A", RS_A, eA);
      checkOutput("RS_inst_pc", RS_inst_pc, ePc);
      checkOutput("RS_inst_code", 32'(RS_inst_code), 32'(eCode));
      checkOutput("RS_inst_rob_id", RS_inst_rob_id, eRob);
   endtask

   // Apply the currently driven inputs for one clock and compare against the model afterwards.
   task automatic applyStimulus();
      assert (!(iss_flag && !rst && !rollback && rdy && modelCount() == N))
         else $display("[TB] protocol violation: dispatch while rs_full");
      modelStep();
      @(posedge clk);
      #1;
      checkModel();
   endtask

   task automatic clearInputs();
      rst = 1'b0; rdy = 1'b1; rollback = 1'b0; iss_flag = 1'b0;
      iss_inst_code = '0; iss_Q1_busy = 1'b0; iss_Q2_busy = 1'b0;
      iss_Q1 = '0; iss_Q2 = '0; iss_rob_id = '0;
      iss_V1 = '0; iss_V2 = '0; iss_A = '0; iss_pc = '0;
      ex_cdb_flag = 1'b0; ex_cdb_rob_id = '0; ex_cdb_val = '0;
      ld_cdb_flag = 1'b0; ld_cdb_rob_id = '0; ld_cdb_val = '0;
   endtask

   task automatic setIssue(input logic [5:0] code, input logic b1, input logic [RW-1:0] t1,
                           input logic [31:0] v1, input logic b2, input logic [RW-1:0] t2,
                           input logic [31:0] v2, input logic [31:0] a, input logic [RW-1:0] rob);
      iss_flag = 1'b1; iss_inst_code = code;
      iss_Q1_busy = b1; iss_Q1 = t1; iss_V1 = v1;
      iss_Q2_busy = b2; iss_Q2 = t2; iss_V2 = v2;
      iss_A = a; iss_pc = 32'h1000 + 32'(rob) * 4; iss_rob_id = rob;
   endtask

   initial begin
      clearInputs();
      rst = 1'b1;
      applyStimulus();
      applyStimulus();
      clearInputs();
      checkOutput("reset_flag", 32'(RS_flag), 32'd0);
      checkOutput("reset_full", 32'(rs_full), 32'd0);
      checkOutput("reset_rob", RS_inst_rob_id, 32'd0);
      checkOutput("reset_v1", RS_V1, 32'd0);

      // Basic issue with both operands ready.
      setIssue(OP_ADDI, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd0, 32'd3, 4'd2);
      applyStimulus();
      clearInputs();
      checkOutput("basic_t1_flag", 32'(RS_flag), 32'd0);
      applyStimulus();
      checkOutput("basic_flag", 32'(RS_flag), 32'd1);
      checkOutput("basic_v1", RS_V1, 32'd5);
      checkOutput("basic_a", RS_A, 32'd3);
      checkOutput("basic_rob", RS_inst_rob_id, 32'd2);
      checkOutput("basic_code", 32'(RS_inst_code), 32'(OP_ADDI));
      applyStimulus();
      checkOutput("basic_pulse", 32'(RS_flag), 32'd0);

      // Wakeup from the load bus.
      setIssue(OP_ADD, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'd10, 32'd0, 4'd4);
      applyStimulus();
      clearInputs();
      applyStimulus();
      checkOutput("ldwake_wait", 32'(RS_flag), 32'd0);
      ld_cdb_flag = 1'b1; ld_cdb_rob_id = 4'd7; ld_cdb_val = 32'h20;
      applyStimulus();
      clearInputs();
      checkOutput("ldwake_t1", 32'(RS_flag), 32'd0);
      applyStimulus();
      checkOutput("ldwake_flag", 32'(RS_flag), 32'd1);
      checkOutput("ldwake_v1", RS_V1, 32'h20);
      checkOutput("ldwake_v2", RS_V2, 32'd10);
      applyStimulus();

      // Same-cycle bypass from the ALU bus; upper tag bits must be ignored.
      setIssue(OP_SUB, 1'b0, 4'd0, 32'd1, 1'b1, 4'd3, 32'd0, 32'd0, 4'd6);
      ex_cdb_flag = 1'b1; ex_cdb_rob_id = 32'hABCD_0003; ex_cdb_val = 32'hFFFF_FFFF;
      applyStimulus();
      clearInputs();
      applyStimulus();
      checkOutput("bypass_flag", 32'(RS_flag), 32'd1);
      checkOutput("bypass_v2", RS_V2, 32'hFFFF_FFFF);
      checkOutput("bypass_rob", RS_inst_rob_id, 32'd6);
      applyStimulus();

      // Fill all entries; entry i waits on tag i and carries rob i.
      for (int i = 0; i < N; i++) begin
         setIssue(OP_ADD, 1'b1, RW'(i), 32'd0, 1'b0, 4'd0, 32'(i), 32'd0, RW'(i));
         applyStimulus();
      end
      clearInputs();
      checkOutput("fill_full", 32'(rs_full), 32'd1);
      ex_cdb_flag = 1'b1; ex_cdb_rob_id = 32'd5; ex_cdb_val = 32'h55;
      applyStimulus();
      clearInputs();
      checkOutput("fill_still_full", 32'(rs_full), 32'd1);
      applyStimulus();
      checkOutput("fill_e5_flag", 32'(RS_flag), 32'd1);
      checkOutput("fill_e5_rob", RS_inst_rob_id, 32'd5);
      checkOutput("fill_e5_v1", RS_V1, 32'h55);
      checkOutput("fill_full_drop", 32'(rs_full), 32'd0);
      ex_cdb_flag = 1'b1; ex_cdb_rob_id = 32'd9; ex_cdb_val = 32'h99;
      ld_cdb_flag = 1'b1; ld_cdb_rob_id = 4'd3; ld_cdb_val = 32'h33;
      applyStimulus();
      clearInputs();
      applyStimulus();
      checkOutput("order_first", RS_inst_rob_id, 32'd3);
      applyStimulus();
      checkOutput("order_second", RS_inst_rob_id, 32'd9);
      checkOutput("order_second_flag", 32'(RS_flag), 32'd1);
      applyStimulus();
      checkOutput("order_done", 32'(RS_flag), 32'd0);

      // Rollback clears everything, including a same-cycle dispatch.
      rollback = 1'b1;
      applyStimulus();
      clearInputs();
      for (int i = 0; i < 4; i++) begin
         setIssue(OP_ADD, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, RW'(i));
         applyStimulus();
      end
      setIssue(OP_ADDI, 1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 32'd0, 32'd0, 4'd14);
      rollback = 1'b1;
      applyStimulus();
      clearInputs();
      checkOutput("rollback_full", 32'(rs_full), 32'd0);
      ex_cdb_flag = 1'b1; ex_cdb_rob_id = 32'd12;
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkOutput("rollback_noflag", 32'(RS_flag), 32'd0);
      end
      clearInputs();

      // rdy low freezes a ready entry.
      setIssue(OP_ADDI, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 32'd0, 32'd1, 4'd11);
      applyStimulus();
      clearInputs();
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("rdylow_flag", 32'(RS_flag), 32'd0);
      end
      rdy = 1'b1;
      applyStimulus();
      checkOutput("rdyback_flag", 32'(RS_flag), 32'd1);
      checkOutput("rdyback_rob", RS_inst_rob_id, 32'd11);
      applyStimulus();

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         clearInputs();
         rst      = ($urandom_range(0, 299) == 0);
         rollback = ($urandom_range(0, 79) == 0);
         rdy      = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 2) != 0 && modelCount() < N) begin
            setIssue(6'($urandom_range(0, 63)), 1'($urandom), RW'($urandom), $urandom,
                     1'($urandom), RW'($urandom), $urandom, $urandom, RW'($urandom));
         end
         ex_cdb_flag   = 1'($urandom);
         ex_cdb_rob_id = $urandom;
         ex_cdb_val    = $urandom;
         ld_cdb_flag   = 1'($urandom);
         ld_cdb_rob_id = RW'($urandom);
         ld_cdb_val    = $urandom;
         applyStimulus();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
